// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer and its address checker.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFC00_0000;
    localparam logic [31:0] PC_INC             = 32'd4;

    // Saturating increment used by the retired-instruction counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational legality check for a word-addressed memory byte pointer.
module fetch_addr_check #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [31:0] pc_i,
    output logic        legal_o
);

    localparam int unsigned HI_LSB = ADDR_W + 2;

    logic upper_zero;
    logic aligned;

    assign aligned = (pc_i[1:0] == 2'b00);

    // When the memory spans the full 32-bit space there are no upper bits to check.
    if (HI_LSB < 32) begin : g_hi
        assign upper_zero = (pc_i[31:HI_LSB] == '0);
    end else begin : g_full
        assign upper_zero = 1'b1;
    end

    assign legal_o = aligned && upper_zero;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner: loads instruction memory in IDLE, fetches one word per cycle in RUN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       fault_pc,
    output logic [31:0]       retired
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic [31:0] next_pc_c;
    logic        advance_c;
    logic        halt_hit_c;
    logic        next_legal_c;

    // Next-PC selection: redirect beats stall, stall beats HALT detection.
    always_comb begin
        next_pc_c  = pc_q + PC_INC;
        advance_c  = 1'b0;
        halt_hit_c = 1'b0;
        if (redirect_valid) begin
            next_pc_c = redirect_pc;
            advance_c = 1'b1;
        end else if (stall) begin
            next_pc_c = pc_q;
        end else if (imem_rdata == HALT_INSTR) begin
            next_pc_c  = pc_q;
            halt_hit_c = 1'b1;
        end else begin
            advance_c = 1'b1;
        end
    end

    fetch_addr_check #(
        .ADDR_W (ADDR_W)
    ) u_addr_check (
        .pc_i    (next_pc_c),
        .legal_o (next_legal_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            retired_q  <= '0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            retired_q  <= retired_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        retired_d  = retired_q;
        fault_pc_d = fault_pc_q;
        case (state_q)
            S_IDLE, S_HALT, S_FAULT: begin
                if (start) begin
                    state_d    = S_RUN;
                    pc_d       = RESET_PC;
                    retired_d  = '0;
                    fault_pc_d = '0;
                end
            end
            S_RUN: begin
                if (advance_c) begin
                    if (next_legal_c) begin
                        pc_d      = next_pc_c;
                        retired_d = sat_inc(retired_q);
                    end else begin
                        state_d    = S_FAULT;
                        fault_pc_d = next_pc_c;
                    end
                end else if (halt_hit_c) begin
                    state_d = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory port: loader owns it in IDLE, otherwise it follows the PC.
    always_comb begin
        imem_we    = 1'b0;
        imem_wdata = '0;
        imem_addr  = pc_q[ADDR_W+1:2];
        if (state_q == S_IDLE) begin
            imem_addr = '0;
            if (ld_valid) begin
                imem_we    = 1'b1;
                imem_addr  = ld_addr;
                imem_wdata = ld_data;
            end
        end
    end

    assign ld_ready    = (state_q == S_IDLE);
    assign instr_valid = (state_q == S_RUN);
    assign halted      = (state_q == S_HALT);
    assign fault       = (state_q == S_FAULT);
    assign pc          = pc_q;
    assign instr       = imem_rdata;
    assign fault_pc    = fault_pc_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a behavioural instruction memory.
module tb_fetch_sequencer;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DEPTH      = 1 << ADDR_W;
    localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_we;
    logic [31:0]       imem_wdata;
    logic [31:0]       imem_rdata;
    logic              stall;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              halted;
    logic              fault;
    logic [31:0]       fault_pc;
    logic [31:0]       retired;

    logic [31:0] mem       [DEPTH];
    logic [31:0] model_mem [DEPTH];
    exp_t        exp_q     [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
    end
    assign imem_rdata = mem[imem_addr];

    fetch_sequencer #(
        .ADDR_W     (ADDR_W),
        .RESET_PC   (32'h0),
        .HALT_INSTR (HALT_INSTR)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .imem_addr      (imem_addr),
        .imem_we        (imem_we),
        .imem_wdata     (imem_wdata),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .halted         (halted),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .retired        (retired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] p);
        exp_t e;
        e.pc    = p;
        e.instr = model_mem[p[ADDR_W+1:2]];
        exp_q.push_back(e);
    endtask

    // Advance one clock; every valid fetch is matched against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (instr_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", pc, e.pc);
                check("sb_instr", instr, e.instr);
            end
        end
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        ld_valid     = 1'b1;
        ld_addr      = a;
        ld_data      = d;
        model_mem[a] = d;
        #1;
        check("ld_ready", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        ld_valid       = 1'b0;
        ld_addr        = '0;
        ld_data        = '0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]       = '0;
            model_mem[i] = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_retired", retired, 32'd0);
        check("rst_fault_pc", fault_pc, 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        rst_n = 1'b1;

        // Load then run to HALT.
        load_word(8'd0, 32'h1);
        load_word(8'd1, 32'h2);
        load_word(8'd2, 32'h3);
        load_word(8'd3, HALT_INSTR);
        load_word(8'd8, 32'h111);
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        tick();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_valid", 32'(instr_valid), 32'd0);
        check("halt_pc", pc, 32'hC);
        check("halt_retired", retired, 32'd3);

        // Stall held three cycles at pc=4.
        push(32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_retired", retired, 32'd0);
        check("restart_halted", 32'(halted), 32'd0);
        push(32'h4);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(32'h4);
            tick();
            check("stall_retired", retired, 32'd1);
        end
        stall = 1'b0;
        push(32'h8);
        tick();
        check("release_retired", retired, 32'd2);

        // Redirect wins over stall.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        stall          = 1'b1;
        push(32'h20);
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        check("redir_retired", retired, 32'd3);

        // Misaligned redirect target faults.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        tick();
        redirect_valid = 1'b0;
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_fault_pc", fault_pc, 32'h22);
        check("mis_pc", pc, 32'h20);
        check("mis_retired", retired, 32'd3);
        check("mis_valid", 32'(instr_valid), 32'd0);
        tick();
        check("mis_fault_hold", 32'(fault), 32'd1);

        // Sequential run past the last word faults without wrapping.
        push(32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_fault", 32'(fault), 32'd0);
        check("restart_fault_pc", fault_pc, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3F0;
        push(32'h3F0);
        tick();
        redirect_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            push(32'h3F0 + 32'(4 * i));
            tick();
        end
        tick();
        check("ovf_fault", 32'(fault), 32'd1);
        check("ovf_fault_pc", fault_pc, 32'h400);
        check("ovf_pc", pc, 32'h3FC);
        check("ovf_retired", retired, 32'd4);

        // Asynchronous reset mid-run at pc=8.
        push(32'h0); push(32'h4); push(32'h8);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_pc", pc, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_retired", retired, 32'd0);
        check("arst_ld_ready", 32'(ld_ready), 32'd1);
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start together with a load; later loads are ignored.
        ld_valid     = 1'b1;
        ld_addr      = 8'd5;
        ld_data      = 32'hABCD;
        model_mem[5] = 32'hABCD;
        start        = 1'b1;
        #1;
        check("sl_imem_we", 32'(imem_we), 32'd1);
        check("sl_imem_addr", 32'(imem_addr), 32'd5);
        check("sl_imem_wdata", imem_wdata, 32'hABCD);
        push(32'h0);
        tick();
        start   = 1'b0;
        ld_addr = 8'd6;
        ld_data = 32'hDEAD;
        #1;
        check("run_ld_ready", 32'(ld_ready), 32'd0);
        check("run_imem_we", 32'(imem_we), 32'd0);
        check("run_imem_wdata", imem_wdata, 32'd0);
        check("run_imem_addr", 32'(imem_addr), 32'd0);
        push(32'h4);
        tick();
        ld_valid       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h14;
        push(32'h14);
        tick();
        redirect_valid = 1'b0;
        push(32'h18);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hC;
        push(32'hC);
        tick();
        redirect_valid = 1'b0;
        tick();
        check("end_halted", 32'(halted), 32'd1);
        check("end_retired", retired, 32'd4);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

- Owns the program counter and sequences the word-addressed instruction memory.
- Has two phases:
  - **IDLE:** a loader writes the program into instruction memory.
  - **RUN:** the block fetches one instruction per cycle, advancing, stalling or redirecting the PC.
- Detects the HALT instruction and illegal PC values.
- Sits between the instruction memory (combinational read, synchronous write) and the decode stage of the mini-MIPS core.

## Interface

Parameters:
- ADDR_W, 8, memory word-address width; depth = 2^ADDR_W words.
- RESET_PC, 32'h0000_0000, PC loaded on reset and on every start; must be word-aligned and in range.
- HALT_INSTR, 32'hFC00_0000, instruction encoding that stops execution.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin execution at RESET_PC; accepted in IDLE, HALT, FAULT.
- ld_valid  in  1  loader write request.
- ld_ready  out  1  loader write accepted this cycle (high only in IDLE).
- ld_addr  in  ADDR_W  loader word address.
- ld_data  in  32  loader write data.
- imem_addr  out  ADDR_W  memory word address.
- imem_we  out  1  memory write enable.
- imem_wdata  out  32  memory write data.
- imem_rdata  in  32  memory read data, combinational from imem_addr.
- stall  in  1  hold PC this cycle.
- redirect_valid  in  1  load redirect_pc as next PC.
- redirect_pc  in  32  branch/jump byte target.
- pc  out  32  current fetch byte address (registered).
- instr  out  32  instruction at pc (combinational pass-through of imem_rdata).
- instr_valid  out  1  instr is valid (state RUN).
- halted  out  1  state HALT.
- fault  out  1  state FAULT.
- fault_pc  out  32  offending PC, captured on FAULT entry.
- retired  out  32  count of instructions advanced past, saturating at 32'hFFFF_FFFF.

## Operation

**States and transitions.**
- IDLE:
  - start → RUN.
- RUN:
  - illegal next PC → FAULT.
  - HALT_INSTR fetched → HALT.
- HALT:
  - start → RUN.
- FAULT:
  - start → RUN.
- Any start transition sets pc=RESET_PC, clears retired and clears fault_pc.

**IDLE.**
- ld_ready=1.
- A write occurs when ld_valid=1: imem_we=1, imem_addr=ld_addr, imem_wdata=ld_data.
- start together with ld_valid in the same cycle: the write completes, then RUN begins the next cycle.

**Address mux.**
- Outside IDLE: imem_we=0, imem_wdata=0, imem_addr=pc[ADDR_W+1:2].
- In IDLE with ld_valid=0: imem_addr=0.

**RUN, next-PC priority per cycle.**
1. redirect_valid: next = redirect_pc. Redirect wins over stall and over HALT detection.
2. stall: next = pc.
3. instr==HALT_INSTR: go to HALT; pc holds the halt instruction address; retired does not increment.
4. Otherwise: next = pc+4.

**Illegal next PC.**
- Illegal means next[1:0]≠0, or next[31:ADDR_W+2]≠0. Sequential overflow (pc+4 past the last word) is illegal; it does not wrap.
- On an illegal next PC: go to FAULT, fault_pc=next, pc unchanged.

**retired counter.**
- Increments by 1 on each RUN cycle where the PC advances (case 1 or 4) and no fault occurs.

**Outside RUN.**
- stall and redirect_valid are ignored.
- ld_valid is ignored outside IDLE; ld_ready=0.

## Timing

- **Reset values:**
  - state IDLE; pc=RESET_PC; retired=0; fault_pc=0.
  - instr_valid=0, halted=0, fault=0, ld_ready=1 (IDLE).
  - imem_we=0, imem_wdata=0, imem_addr=0.
- **Fetch latency:** zero. instr is valid in the same cycle pc is presented; one instruction per cycle at full rate.
- **Redirect:** redirect_pc appears on pc the cycle after redirect_valid. There are no bubbles and no wrong-path fetch beyond the current cycle.
- **Loader handshake:** single-cycle; ld_valid&&ld_ready is the write. No back-pressure inside IDLE.
- **Reset asserted mid-RUN or mid-load:** immediate return to reset values. Memory contents are not cleared.
- **State outputs:** halted and fault assert in the cycle after the detecting edge and stay high until start.

## Structure

- **Package fetch_pkg:**
  - state enum {S_IDLE, S_RUN, S_HALT, S_FAULT}.
  - default HALT_INSTR constant.
  - PC increment constant 4.
- **Sub-module fetch_addr_check:** purely combinational. Takes a 32-bit next PC and ADDR_W, and returns legal/illegal. It is reused later by the data-memory controller.
- **Main module:** state register, PC register, retired counter, memory port mux.

## Test plan

- **Load then run:**
  - Stimulus: load words 0–3 = 32'h1,32'h2,32'h3,HALT_INSTR, then pulse start.
  - Required: instr sequence 1,2,3,HALT on pc 0,4,8,12; halted=1 next cycle; pc=12; retired=3.
- **Stall:**
  - Stimulus: stall held 3 cycles at pc=4.
  - Required: pc stays 4, instr stays 32'h2, retired unchanged; advances to 8 on release.
- **Redirect vs stall:**
  - Stimulus: redirect_valid=1, redirect_pc=32'h20, stall=1 in the same cycle.
  - Required: pc=32'h20 next cycle; retired +1.
- **Faults:**
  - Stimulus: redirect_pc=32'h22.
  - Required: fault=1, fault_pc=32'h22, pc unchanged.
  - Stimulus (ADDR_W=8): run sequentially to pc=32'h3FC.
  - Required: FAULT with fault_pc=32'h400.
- **Start with load:**
  - Stimulus: start and ld_valid (addr 5, data 32'hABCD) in the same IDLE cycle.
  - Required: word 5 written; RUN from RESET_PC next cycle; subsequent ld_valid ignored, ld_ready=0.
- **Async reset:**
  - Stimulus: rst_n low mid-RUN at pc=8.
  - Required: immediately IDLE, pc=RESET_PC, retired=0, memory preserved; restart fetches the same program.
